// File: rtl/dpi_stream_sequencer_if.sv
// Matcher-bank front-end bus: packet byte stream in, enable-table config,
// and the shared matcher control bus out. The slave modport is the
// sequencer's view; the master modport is the upstream/bench view.
interface dpi_stream_sequencer_if #(
    parameter int KEY_W     = 32,
    parameter int NUM_REGEX = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic [7:0]           in_data;
    logic                 in_sop;
    logic                 in_eop;
    logic [KEY_W-1:0]     in_key;
    logic                 cfg_we;
    logic [5:0]           cfg_addr;
    logic [NUM_REGEX-1:0] cfg_mask;
    logic                 load_state;
    logic [5:0]           stream_id;
    logic                 new_stream_id;
    logic [NUM_REGEX-1:0] enable;
    logic [7:0]           char_in;
    logic                 char_in_vld;
    logic                 eop;
    logic                 busy;

    modport slave (
        input  in_valid, in_data, in_sop, in_eop, in_key,
        input  cfg_we, cfg_addr, cfg_mask,
        output in_ready, load_state, stream_id, new_stream_id, enable,
        output char_in, char_in_vld, eop, busy
    );

    modport master (
        output in_valid, in_data, in_sop, in_eop, in_key,
        output cfg_we, cfg_addr, cfg_mask,
        input  in_ready, load_state, stream_id, new_stream_id, enable,
        input  char_in, char_in_vld, eop, busy
    );
endinterface

// File: rtl/dpi_stream_sequencer.sv
// dpi_stream_sequencer: maps a flow key to a 6-bit stream id through a
// 64-entry round-robin associative table, then sequences each packet onto
// the matcher bus as load_state -> settle -> bytes -> drain -> eop.
// Optional statistics counters (pkt_cnt, new_stream_cnt, evict_cnt) are
// built only when the macro DPI_SEQ_STATS_EN is defined.
module dpi_stream_sequencer #(
    parameter int KEY_W     = 32,
    parameter int NUM_REGEX = 8,
    parameter int EOP_DELAY = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    dpi_stream_sequencer_if.slave bus
`ifdef DPI_SEQ_STATS_EN
    ,
    output logic [31:0]           pkt_cnt,
    output logic [31:0]           new_stream_cnt,
    output logic [31:0]           evict_cnt
`endif
);

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        LOAD,
        SETTLE,
        STREAM,
        DRAIN,
        EOP
    } state_t;

    localparam logic [7:0] DrainLast = 8'(EOP_DELAY);

    state_t               state_q;
    logic [KEY_W-1:0]     capKey_q;
    logic [7:0]           capByte_q;
    logic                 capEop_q;
    logic [7:0]           drainCnt_q;

    logic [63:0]          keyValid_q;
    logic [KEY_W-1:0]     keyTable_q [64];
    logic [5:0]           allocPtr_q;
    logic [NUM_REGEX-1:0] enTable_q [64];

    logic                 inReady_q;
    logic                 loadState_q;
    logic [5:0]           streamId_q;
    logic                 newStream_q;
    logic [NUM_REGEX-1:0] enable_q;
    logic [7:0]           charIn_q;
    logic                 charVld_q;
    logic                 eop_q;

    logic                 hit_d;
    logic [5:0]           hitIdx_d;
    logic [5:0]           resolvedId_d;
    logic                 allocate_d;
    logic                 evict_d;

    // Parallel key compare against every valid entry; lowest index wins.
    always_comb begin
        hit_d    = 1'b0;
        hitIdx_d = 6'd0;
        for (int i = 0; i < 64; i++) begin
            if (!hit_d && keyValid_q[i] && (keyTable_q[i] == capKey_q)) begin
                hit_d    = 1'b1;
                hitIdx_d = 6'(i);
            end
        end
    end

    assign resolvedId_d = hit_d ? hitIdx_d : allocPtr_q;
    assign allocate_d   = (state_q == LOOKUP) && !hit_d;
    assign evict_d      = allocate_d && keyValid_q[allocPtr_q];

    // Key storage needs no reset: an entry is only trusted once its valid bit is set.
    always_ff @(posedge clk) begin
        if (allocate_d) begin
            keyTable_q[allocPtr_q] <= capKey_q;
        end
    end

    // Valid bits and round-robin allocation pointer; a miss claims the oldest slot.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            keyValid_q <= '0;
            allocPtr_q <= 6'd0;
        end else if (allocate_d) begin
            keyValid_q[allocPtr_q] <= 1'b1;
            allocPtr_q             <= allocPtr_q + 6'd1;
        end
    end

    // Enable table written by config; read only at LOOKUP so mid-packet writes wait.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 64; i++) begin
                enTable_q[i] <= '0;
            end
        end else if (bus.cfg_we) begin
            enTable_q[bus.cfg_addr] <= bus.cfg_mask;
        end
    end

    // Packet sequencer with all matcher-bus outputs registered.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            capKey_q    <= '0;
            capByte_q   <= 8'd0;
            capEop_q    <= 1'b0;
            drainCnt_q  <= 8'd0;
            inReady_q   <= 1'b0;
            loadState_q <= 1'b0;
            streamId_q  <= 6'd0;
            newStream_q <= 1'b0;
            enable_q    <= '0;
            charIn_q    <= 8'd0;
            charVld_q   <= 1'b0;
            eop_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    inReady_q <= 1'b1;
                    if (inReady_q && bus.in_valid && bus.in_sop) begin
                        capKey_q  <= bus.in_key;
                        capByte_q <= bus.in_data;
                        capEop_q  <= bus.in_eop;
                        inReady_q <= 1'b0;
                        state_q   <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    streamId_q  <= resolvedId_d;
                    newStream_q <= !hit_d;
                    enable_q    <= enTable_q[resolvedId_d];
                    loadState_q <= 1'b1;
                    state_q     <= LOAD;
                end
                LOAD: begin
                    loadState_q <= 1'b0;
                    state_q     <= SETTLE;
                end
                SETTLE: begin
                    charIn_q   <= capByte_q;
                    charVld_q  <= 1'b1;
                    drainCnt_q <= 8'd0;
                    if (capEop_q) begin
                        state_q <= DRAIN;
                    end else begin
                        inReady_q <= 1'b1;
                        state_q   <= STREAM;
                    end
                end
                STREAM: begin
                    charVld_q <= bus.in_valid;
                    if (bus.in_valid) begin
                        charIn_q <= bus.in_data;
                        if (bus.in_eop) begin
                            inReady_q  <= 1'b0;
                            drainCnt_q <= 8'd0;
                            state_q    <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    charVld_q <= 1'b0;
                    if (drainCnt_q == DrainLast) begin
                        eop_q   <= 1'b1;
                        state_q <= EOP;
                    end else begin
                        drainCnt_q <= drainCnt_q + 8'd1;
                    end
                end
                EOP: begin
                    eop_q     <= 1'b0;
                    inReady_q <= 1'b1;
                    state_q   <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready      = inReady_q;
    assign bus.load_state    = loadState_q;
    assign bus.stream_id     = streamId_q;
    assign bus.new_stream_id = newStream_q;
    assign bus.enable        = enable_q;
    assign bus.char_in       = charIn_q;
    assign bus.char_in_vld   = charVld_q;
    assign bus.eop           = eop_q;
    assign bus.busy          = (state_q != IDLE);

`ifdef DPI_SEQ_STATS_EN
    logic [31:0] pktCnt_q;
    logic [31:0] newCnt_q;
    logic [31:0] evictCnt_q;

    // Free-running statistics, wrapping naturally at 2^32.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pktCnt_q   <= 32'd0;
            newCnt_q   <= 32'd0;
            evictCnt_q <= 32'd0;
        end else begin
            if (eop_q)      pktCnt_q   <= pktCnt_q + 32'd1;
            if (allocate_d) newCnt_q   <= newCnt_q + 32'd1;
            if (evict_d)    evictCnt_q <= evictCnt_q + 32'd1;
        end
    end

    assign pkt_cnt        = pktCnt_q;
    assign new_stream_cnt = newCnt_q;
    assign evict_cnt      = evictCnt_q;
`endif

endmodule

// File: tb/tb_dpi_stream_sequencer.sv
// Self-checking bench for dpi_stream_sequencer: randomized packets are
// compared against a key-map / round-robin reference model.
module tb_dpi_stream_sequencer;

    localparam int KEY_W     = 32;
    localparam int NUM_REGEX = 8;
    localparam int EOP_DELAY = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    dpi_stream_sequencer_if #(.KEY_W(KEY_W), .NUM_REGEX(NUM_REGEX)) bus ();

`ifdef DPI_SEQ_STATS_EN
    logic [31:0] pkt_cnt;
    logic [31:0] new_stream_cnt;
    logic [31:0] evict_cnt;
`endif

    dpi_stream_sequencer #(
        .KEY_W    (KEY_W),
        .NUM_REGEX(NUM_REGEX),
        .EOP_DELAY(EOP_DELAY)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .bus           (bus)
`ifdef DPI_SEQ_STATS_EN
        ,
        .pkt_cnt       (pkt_cnt),
        .new_stream_cnt(new_stream_cnt),
        .evict_cnt     (evict_cnt)
`endif
    );

    int checks   = 0;
    int failures = 0;

    // Observed bus events, collected by the monitor.
    int                   cycle = 0;
    int                   loadCycQ [$];
    logic [5:0]           loadIdQ  [$];
    logic                 loadNewQ [$];
    logic [NUM_REGEX-1:0] loadEnQ  [$];
    logic [7:0]           charQ    [$];
    int                   charCycQ [$];
    int                   eopCycQ  [$];
    logic [5:0]           eopIdQ   [$];
    logic [NUM_REGEX-1:0] eopEnQ   [$];
    int                   exclViol     = 0;
    int                   readyBusyCnt = 0;

    // Bytes driven for the packet in flight.
    logic [7:0] expBytes [$];

    // Reference model: key -> stream id map plus slot ownership for round robin.
    int                   keyMap [logic [31:0]];
    logic [31:0]          ownerKey   [64];
    bit                   ownerValid [64];
    int                   modelPtr;
    logic [NUM_REGEX-1:0] enModel [64];
    bit                   pendValid;
    int                   pendAddr;
    logic [NUM_REGEX-1:0] pendMask;
    int                   expPkt, expNewCnt, expEvict;

    // Monitor sampling on the falling edge, away from the active edge.
    always @(negedge clk) begin
        cycle++;
        if (bus.load_state) begin
            loadCycQ.push_back(cycle);
            loadIdQ.push_back(bus.stream_id);
            loadNewQ.push_back(bus.new_stream_id);
            loadEnQ.push_back(bus.enable);
        end
        if (bus.char_in_vld) begin
            charQ.push_back(bus.char_in);
            charCycQ.push_back(cycle);
        end
        if (bus.eop) begin
            eopCycQ.push_back(cycle);
            eopIdQ.push_back(bus.stream_id);
            eopEnQ.push_back(bus.enable);
        end
        if ((int'(bus.load_state) + int'(bus.char_in_vld) + int'(bus.eop)) > 1) exclViol++;
        if (bus.busy && bus.in_ready) readyBusyCnt++;
    end

    // Watchdog so the run can never hang.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clearObs();
        #1;
        loadCycQ.delete(); loadIdQ.delete(); loadNewQ.delete(); loadEnQ.delete();
        charQ.delete(); charCycQ.delete();
        eopCycQ.delete(); eopIdQ.delete(); eopEnQ.delete();
        expBytes.delete();
    endtask

    task automatic modelReset();
        keyMap.delete();
        for (int i = 0; i < 64; i++) begin
            ownerValid[i] = 1'b0;
            ownerKey[i]   = '0;
            enModel[i]    = '0;
        end
        modelPtr  = 0;
        pendValid = 1'b0;
        expPkt    = 0;
        expNewCnt = 0;
        expEvict  = 0;
    endtask

    task automatic modelLookup(input logic [31:0] key, output int id, output bit isNew);
        if (keyMap.exists(key)) begin
            id    = keyMap[key];
            isNew = 1'b0;
        end else begin
            id    = modelPtr;
            isNew = 1'b1;
            expNewCnt++;
            if (ownerValid[modelPtr]) begin
                keyMap.delete(ownerKey[modelPtr]);
                expEvict++;
            end
            ownerKey[modelPtr]   = key;
            ownerValid[modelPtr] = 1'b1;
            keyMap[key]          = modelPtr;
            modelPtr             = (modelPtr + 1) % 64;
        end
    endtask

    task automatic cfgWrite(input int addr, input logic [NUM_REGEX-1:0] mask, input bit defer);
        bus.cfg_we   = 1'b1;
        bus.cfg_addr = 6'(addr);
        bus.cfg_mask = mask;
        @(negedge clk);
        bus.cfg_we = 1'b0;
        if (defer) begin
            pendValid = 1'b1;
            pendAddr  = addr;
            pendMask  = mask;
        end else begin
            enModel[addr] = mask;
        end
    endtask

    task automatic waitReady();
        int n = 0;
        while (!bus.in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) checkOutput("ready_wait", 64'(bus.in_ready), 64'd1);
    endtask

    // Drives one packet; bubbleMask bit i inserts one idle cycle before beat i.
    task automatic applyStimulus(input logic [31:0] key, input int len, input int bubbleMask);
        logic [7:0] b;
        for (int i = 0; i < len; i++) begin
            b = 8'($urandom);
            if (i > 0 && bubbleMask[i]) begin
                bus.in_valid = 1'b0;
                @(negedge clk);
            end
            bus.in_valid = 1'b0;
            waitReady();
            bus.in_valid = 1'b1;
            bus.in_sop   = (i == 0);
            bus.in_eop   = (i == len - 1);
            bus.in_data  = b;
            bus.in_key   = (i == 0) ? key : 32'($urandom);
            expBytes.push_back(b);
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        bus.in_sop   = 1'b0;
        bus.in_eop   = 1'b0;
    endtask

    task automatic waitEop();
        int n = 0;
        while (eopCycQ.size() == 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
    endtask

    // Compares the recorded packet against the reference model.
    task automatic checkPacket(input logic [31:0] key, input bit consecutive);
        int                   expId;
        bit                   expNew;
        logic [NUM_REGEX-1:0] expEn;
        int                   nChar;
        modelLookup(key, expId, expNew);
        expEn = enModel[expId];
        checkOutput("load_count", 64'(loadCycQ.size()), 64'd1);
        checkOutput("eop_count", 64'(eopCycQ.size()), 64'd1);
        checkOutput("char_count", 64'(charQ.size()), 64'(expBytes.size()));
        if (loadCycQ.size() > 0) begin
            checkOutput("stream_id", 64'(loadIdQ[0]), 64'(expId));
            checkOutput("new_stream_id", 64'(loadNewQ[0]), 64'(expNew));
            checkOutput("enable", 64'(loadEnQ[0]), 64'(expEn));
            if (charCycQ.size() > 0)
                checkOutput("first_char_lat", 64'(charCycQ[0] - loadCycQ[0]), 64'd2);
        end
        nChar = (charQ.size() < expBytes.size()) ? charQ.size() : expBytes.size();
        for (int i = 0; i < nChar; i++) checkOutput("char_byte", 64'(charQ[i]), 64'(expBytes[i]));
        if (consecutive && charCycQ.size() > 0)
            checkOutput("char_span", 64'(charCycQ[charCycQ.size()-1] - charCycQ[0]),
                        64'(expBytes.size() - 1));
        if (eopCycQ.size() > 0 && charCycQ.size() > 0) begin
            checkOutput("eop_lat", 64'(eopCycQ[0] - charCycQ[charCycQ.size()-1]), 64'(EOP_DELAY + 1));
            checkOutput("eop_stream_id", 64'(eopIdQ[0]), 64'(expId));
            checkOutput("eop_enable", 64'(eopEnQ[0]), 64'(expEn));
        end
        expPkt++;
`ifdef DPI_SEQ_STATS_EN
        checkOutput("pkt_cnt", 64'(pkt_cnt), 64'(expPkt));
        checkOutput("new_stream_cnt", 64'(new_stream_cnt), 64'(expNewCnt));
        checkOutput("evict_cnt", 64'(evict_cnt), 64'(expEvict));
`endif
        if (pendValid) begin
            enModel[pendAddr] = pendMask;
            pendValid         = 1'b0;
        end
        clearObs();
    endtask

    task automatic checkIdleZero(input string tag);
        checkOutput({tag, "_load"}, 64'(bus.load_state), 64'd0);
        checkOutput({tag, "_vld"}, 64'(bus.char_in_vld), 64'd0);
        checkOutput({tag, "_eop"}, 64'(bus.eop), 64'd0);
        checkOutput({tag, "_busy"}, 64'(bus.busy), 64'd0);
        checkOutput({tag, "_ready"}, 64'(bus.in_ready), 64'd0);
        checkOutput({tag, "_sid"}, 64'({bus.stream_id, bus.new_stream_id, bus.enable, bus.char_in}), 64'd0);
    endtask

    task automatic applyReset();
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_sop   = 1'b0;
        bus.in_eop   = 1'b0;
        bus.cfg_we   = 1'b0;
        repeat (2) @(negedge clk);
        checkIdleZero("reset");
`ifdef DPI_SEQ_STATS_EN
        checkOutput("reset_pkt_cnt", 64'(pkt_cnt), 64'd0);
`endif
        rst_n = 1'b1;
        modelReset();
        clearObs();
        @(negedge clk);
        checkOutput("ready_after_reset", 64'(bus.in_ready), 64'd1);
    endtask

    initial begin
        logic [31:0] salt;
        logic [31:0] firstKey;
        logic [31:0] k;
        int          len;
        int          mask;
        bit          cons;

        bus.in_valid = 1'b0; bus.in_sop = 1'b0; bus.in_eop = 1'b0;
        bus.in_data  = 8'd0; bus.in_key = '0;
        bus.cfg_we   = 1'b0; bus.cfg_addr = 6'd0; bus.cfg_mask = '0;

        // Reset state and first allocation.
        applyReset();
        applyStimulus(32'hA5A5A5A5, 3, 0);
        waitEop();
        checkPacket(32'hA5A5A5A5, 1'b1);

        // Same key after configuring its enable mask: hit on id 0.
        cfgWrite(0, 8'h05, 1'b0);
        applyStimulus(32'hA5A5A5A5, 4, 0);
        waitEop();
        checkPacket(32'hA5A5A5A5, 1'b1);

        // A config write to the active id during a packet applies only to the next one.
        fork
            applyStimulus(32'hA5A5A5A5, 6, 0);
            begin
                repeat (5) @(negedge clk);
                cfgWrite(0, 8'h3C, 1'b1);
            end
        join
        waitEop();
        checkPacket(32'hA5A5A5A5, 1'b1);
        applyStimulus(32'hA5A5A5A5, 2, 0);
        waitEop();
        checkPacket(32'hA5A5A5A5, 1'b1);

        // A stray non-sop beat in IDLE is dropped.
        waitReady();
        bus.in_valid = 1'b1; bus.in_sop = 1'b0; bus.in_data = 8'h77;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (5) @(negedge clk);
        checkOutput("stray_no_load", 64'(loadCycQ.size()), 64'd0);
        checkOutput("stray_no_char", 64'(charQ.size()), 64'd0);
        clearObs();

        // Single-byte packet: in_ready held low for the whole busy window.
        k = $urandom;
        readyBusyCnt = 0;
        applyStimulus(k, 1, 0);
        waitEop();
        checkOutput("single_ready_low", 64'(readyBusyCnt), 64'd0);
        checkPacket(k, 1'b1);

        // Five bytes with three bubbles inside STREAM.
        k = $urandom;
        applyStimulus(k, 5, 5'b11100);
        waitEop();
        checkPacket(k, 1'b0);

        // Fill the table with 65 distinct keys, then revisit the first (evicted) key.
        applyReset();
        salt     = $urandom;
        firstKey = salt;
        for (int i = 0; i < 65; i++) begin
            k    = salt + 32'(i * 7);
            len  = $urandom_range(1, 4);
            mask = int'($urandom_range(0, 15)) & ~3;
            cons = 1'b1;
            for (int j = 2; j < len; j++) if (mask[j]) cons = 1'b0;
            if ((i % 16) == 3) cfgWrite(i, 8'($urandom), 1'b0);
            applyStimulus(k, len, mask);
            waitEop();
            checkPacket(k, cons);
        end
        applyStimulus(firstKey, 2, 0);
        waitEop();
        checkPacket(firstKey, 1'b1);

        // Reset during STREAM abandons the packet; the key is forgotten.
        applyReset();
        k = $urandom;
        applyStimulus(k, 2, 0);
        waitEop();
        checkPacket(k, 1'b1);
        waitReady();
        bus.in_valid = 1'b1; bus.in_sop = 1'b1; bus.in_eop = 1'b0;
        bus.in_key = k; bus.in_data = 8'h11;
        @(negedge clk);
        bus.in_valid = 1'b0; bus.in_sop = 1'b0;
        waitReady();
        bus.in_valid = 1'b1; bus.in_data = 8'h22;
        @(negedge clk);
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        checkIdleZero("midrst");
`ifdef DPI_SEQ_STATS_EN
        checkOutput("midrst_pkt_cnt", 64'(pkt_cnt), 64'd0);
`endif
        rst_n = 1'b1;
        modelReset();
        clearObs();
        repeat (10) @(negedge clk);
        checkOutput("midrst_no_eop", 64'(eopCycQ.size()), 64'd0);
        checkOutput("midrst_no_char", 64'(charQ.size()), 64'd0);
        applyStimulus(k, 3, 0);
        waitEop();
        checkPacket(k, 1'b1);

        checkOutput("mutual_exclusion", 64'(exclViol), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dpi_stream_sequencer.md
Name: dpi_stream_sequencer

Overview:
Upstream front-end for the per-regex cancid matcher bank. Accepts a packet byte stream tagged with a flow key and maps the key to a 6-bit stream id through a 64-entry associative table. Drives the shared matcher control bus: load_state, stream_id, new_stream_id, enable mask, char_in/char_in_vld and eop. Sequences each packet so that every matcher restores its saved state, consumes all bytes, and commits its state and count exactly once per packet.

Parameters:
KEY_W, 32, flow key width
NUM_REGEX, 8, number of matcher instances driven; width of enable mask
EOP_DELAY, 2, idle cycles between last char_in_vld and the eop pulse (covers matcher accept/state pipeline)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
in_valid  in  1  input beat valid
in_ready  out  1  input beat accepted when in_valid & in_ready
in_data  in  8  packet byte
in_sop  in  1  first byte of packet; in_key is sampled on this beat
in_eop  in  1  last byte of packet
in_key  in  KEY_W  flow key
cfg_we  in  1  enable-table write strobe
cfg_addr  in  6  stream id being configured
cfg_mask  in  NUM_REGEX  per-regex enable bits for that stream id
load_state  out  1  one-cycle pulse: matchers restore state
stream_id  out  6  stream id of the current packet; held from load_state through eop
new_stream_id  out  1  valid with load_state; 1 = freshly allocated entry
enable  out  NUM_REGEX  per-regex enable for the current stream id; held like stream_id
char_in  out  8  byte to matchers
char_in_vld  out  1  char_in valid
eop  out  1  one-cycle end-of-packet commit pulse
busy  out  1  FSM not in IDLE

Behaviour:
- Reset values: all outputs 0; in_ready 0; key table valid bits cleared; allocation pointer 0; enable table cleared to 0. A reset mid-packet abandons the packet with no eop. Upstream must restart at an sop.
- Key table: 64 entries of {valid, key}. Compare is single-cycle and fully parallel. A hit gives stream_id = matching index and new_stream_id = 0. A miss writes the key at the allocation pointer, gives stream_id = pointer and new_stream_id = 1, then increments the pointer mod 64 (wraps 63->0). When the table is full, the oldest allocated entry is overwritten (round robin).
- Enable table: 64 x NUM_REGEX registers written by cfg_we. `enable` is read from this table at LOOKUP and held for the whole packet. A cfg write to the active stream id has no effect until the next packet.
- FSM:
  - IDLE: in_ready=1. An in_valid & in_sop beat captures key, byte and eop flag, then goes to LOOKUP. A non-sop beat is accepted and dropped.
  - LOOKUP (1 cycle): in_ready=0. Resolves stream_id, new_stream_id and enable, then goes to LOAD.
  - LOAD (1 cycle): load_state=1, then goes to SETTLE.
  - SETTLE (1 cycle): nothing asserted. The matcher registers state_in_vld during this cycle.
  - STREAM: first emits the captured sop byte with char_in_vld=1. After that in_ready=1 and each accepted beat produces char_in=in_data and char_in_vld=1 on the next cycle (registered, 1-cycle latency). Cycles with in_valid=0 give char_in_vld=0. A beat with in_sop set inside STREAM is treated as data. The last byte (eop flag) sends the FSM to DRAIN with in_ready=0. A single-byte packet (sop & eop on the same beat) emits its byte and then goes to DRAIN.
  - DRAIN: counts EOP_DELAY cycles with char_in_vld=0, then goes to EOP.
  - EOP (1 cycle): eop=1, then goes to IDLE. in_ready returns to 1 the following cycle.
- Minimum gap between packets: eop to the next load_state is at least 3 cycles.
- load_state, eop and char_in_vld are mutually exclusive in every cycle.
- stream_id, new_stream_id and enable are stable from the LOOKUP exit until IDLE re-entry.

Optional Feature:
Macro DPI_SEQ_STATS_EN.
- Defined: adds output ports pkt_cnt[31:0] (increments on each eop pulse), new_stream_cnt[31:0] (increments on each miss allocation) and evict_cnt[31:0] (increments on each miss that overwrites a valid entry). All reset to 0 and wrap at 2^32.
- Undefined: these ports and their counters are absent. All other behaviour is identical.

Test Plan:
- After reset, 3-byte packet with key 0xA5A5A5A5: load_state with stream_id=0 and new_stream_id=1; char_in_vld on 3 consecutive cycles starting 2 cycles after load_state; eop exactly EOP_DELAY+1 cycles after the last char.
- Second packet with the same key, after cfg_we writes mask 0x05 to addr 0: stream_id=0, new_stream_id=0, enable=0x05 held through eop.
- 65 distinct keys: the 65th gets stream_id=0 with new_stream_id=1 (wrap/evict); re-sending the first key then misses and gets stream_id=1.
- Single-byte packet (sop & eop on one beat): exactly one char_in_vld, then eop EOP_DELAY+1 cycles later; in_ready=0 from LOOKUP through EOP.
- in_valid toggling mid-packet (5 bytes with 3 bubbles): exactly 5 char_in_vld pulses, byte order preserved, one eop.
- rst_n low during STREAM: all outputs 0 next cycle, no eop; the following packet with the same key gets new_stream_id=1. With DPI_SEQ_STATS_EN defined: pkt_cnt=0 after reset, 1 after the next packet.
